// File: rtl/lr_shift_pipe_pkg.sv
// Shared types and helpers for the left/right shifter family (flat and pipelined variants).
package lr_shift_pipe_pkg;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } shift_dir_e;

    // Encoding 3 is reserved and decodes as a logical shift.
    typedef enum logic [1:0] {
        MODE_LOGICAL = 2'd0,
        MODE_ARITH   = 2'd1,
        MODE_ROTATE  = 2'd2,
        MODE_RSVD    = 2'd3
    } shift_mode_e;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/lr_shift_pipe_stage.sv
// One combinational shifter stage: shifts or rotates by a fixed power-of-two amount when enabled.
module lr_shift_pipe_stage
    import lr_shift_pipe_pkg::*;
#(
    parameter int width  = 8,
    parameter int amount = 1
) (
    input  logic             en,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [width-1:0] din,
    output logic [width-1:0] dout
);

    always_comb begin
        dout = din;
        if (en) begin
            if (mode == MODE_ROTATE) begin
                if (dir == DIR_LEFT) begin
                    dout = (din << amount) | (din >> (width - amount));
                end else begin
                    dout = (din >> amount) | (din << (width - amount));
                end
            end else if (dir == DIR_LEFT) begin
                dout = din << amount;
            end else if (mode == MODE_ARITH) begin
                // Each arithmetic stage keeps the MSB, so the original sign carries through the chain.
                dout = {{amount{din[width-1]}}, din[width-1:amount]};
            end else begin
                dout = din >> amount;
            end
        end
    end

endmodule

// File: rtl/lr_shift_pipe.sv
// Pipelined barrel shifter: one registered stage per shift-amount bit, LSB first, with a global stall.
module lr_shift_pipe
    import lr_shift_pipe_pkg::*;
#(
    parameter  int width = 8,
    localparam int sw    = clog2(width)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iValid,
    output logic             iReady,
    input  logic [width-1:0] iBits,
    input  logic [sw-1:0]    shift,
    input  logic             dir,
    input  logic [1:0]       mode,
    output logic             oValid,
    input  logic             oReady,
    output logic [width-1:0] oBits
);

    logic                          advance;

    logic [sw-1:0]                 valid_q, valid_d, valid_in;
    logic [sw-1:0][width-1:0]      data_q, data_d, data_in, data_sh;
    logic [sw-1:0][sw-1:0]         shift_q, shift_d, shift_in;
    logic [sw-1:0]                 dir_q, dir_d, dir_in;
    logic [sw-1:0][1:0]            mode_q, mode_d, mode_in;

    // The last stage's control fields are carried only for uniformity; nothing downstream reads them.
    logic                          tail_unused;

    assign advance     = !valid_q[sw-1] || oReady;
    assign iReady      = advance;
    assign oValid      = valid_q[sw-1];
    assign oBits       = data_q[sw-1];
    assign tail_unused = ^{shift_q[sw-1], dir_q[sw-1], mode_q[sw-1]};

    for (genvar gi = 0; gi < sw; gi++) begin : g_stage
        if (gi == 0) begin : g_head
            assign valid_in[gi] = iValid;
            assign data_in[gi]  = iBits;
            assign shift_in[gi] = shift;
            assign dir_in[gi]   = dir;
            assign mode_in[gi]  = mode;
        end else begin : g_body
            assign valid_in[gi] = valid_q[gi-1];
            assign data_in[gi]  = data_q[gi-1];
            assign shift_in[gi] = shift_q[gi-1];
            assign dir_in[gi]   = dir_q[gi-1];
            assign mode_in[gi]  = mode_q[gi-1];
        end

        lr_shift_pipe_stage #(
            .width  (width),
            .amount (1 << gi)
        ) u_stage (
            .en   (shift_in[gi][gi]),
            .dir  (dir_in[gi]),
            .mode (mode_in[gi]),
            .din  (data_in[gi]),
            .dout (data_sh[gi])
        );
    end

    // Single shared advance: the whole pipe moves or the whole pipe holds; bubbles move like data.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        shift_d = shift_q;
        dir_d   = dir_q;
        mode_d  = mode_q;
        if (advance) begin
            for (int k = 0; k < sw; k++) begin
                valid_d[k] = valid_in[k];
                data_d[k]  = data_sh[k];
                shift_d[k] = shift_in[k] & ~(sw'(1) << k);
                dir_d[k]   = dir_in[k];
                mode_d[k]  = mode_in[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            data_q  <= '0;
            shift_q <= '0;
            dir_q   <= '0;
            mode_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            shift_q <= shift_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
        end
    end

endmodule

// File: doc/lr_shift_pipe.md
LR_SHIFT_PIPE -- requirements
Module: LRShiftPipe

Interface
REQ-001 The block SHALL have parameter width, default 8, giving the data bit width; legal values are powers of two with width >= 2.
REQ-002 The block SHALL have derived constant sw = clog2(width), giving the shift-amount width and pipeline depth.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port iValid, input, 1 bit: an input word is offered.
REQ-006 The block SHALL have port iReady, output, 1 bit: the block accepts the offered word this cycle.
REQ-007 The block SHALL have port iBits, input, width bits: the word to shift.
REQ-008 The block SHALL have port shift, input, sw bits: the requested shift amount, 0..width-1.
REQ-009 The block SHALL have port dir, input, 1 bit: ShiftDir (Left, Right).
REQ-010 The block SHALL have port mode, input, 2 bits: ShiftMode (Logical, Arith, Rotate; encoding 3 reserved).
REQ-011 The block SHALL have port oValid, output, 1 bit: oBits holds a result.
REQ-012 The block SHALL have port oReady, input, 1 bit: the consumer takes the result this cycle.
REQ-013 The block SHALL have port oBits, output, width bits: the shifted result.

Function
REQ-014 The block SHALL use sw registered stages; stage k (k = 0..sw-1) SHALL conditionally shift by 2^k when bit k of the carried shift amount is set, taking the LSB first.
REQ-015 Each stage SHALL register valid, data, remaining shift bits, dir and mode.
REQ-016 The block SHALL compute a single advance = !oValid || oReady; when advance = 1, all stages SHALL move one step together, and when advance = 0, all stages SHALL hold.
REQ-017 iReady SHALL equal advance, and a word is accepted when iValid && iReady.
REQ-018 Bubbles SHALL propagate and SHALL NOT be collapsed.
REQ-019 An accepted word SHALL appear on oBits with oValid = 1 exactly sw cycles after acceptance when oReady is held high; each stalled cycle SHALL add exactly one cycle.
REQ-020 While oValid = 1 and oReady = 0, oBits and oValid SHALL remain stable.
REQ-021 The block SHALL sustain a throughput of one word per cycle while oReady stays high.
REQ-022 Logical Left SHALL zero-fill on the right, and Logical Right SHALL zero-fill on the left.
REQ-023 Arith Right SHALL fill with the original iBits[width-1]; Arith Left SHALL equal Logical Left.
REQ-024 Rotate SHALL wrap the bits modulo width in the given direction.
REQ-025 Reserved mode 3 SHALL behave as Logical.
REQ-026 A shift of 0 SHALL return iBits unchanged in every mode.
REQ-027 Results SHALL be truncated to width bits, with no carry-out.
REQ-028 Simultaneous accept and output take in the same cycle SHALL be lossless.

Reset
REQ-029 While rst = 0, all stage valid flags SHALL be 0, all data and shift registers SHALL be 0, oValid SHALL be 0, and oBits SHALL be 0; iReady SHALL be 1 because it follows advance.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight words without producing any output.
REQ-031 After reset is released, the first accept SHALL be possible on the next rising clk edge.

Structure
REQ-032 The enums ShiftDir {Left, Right} and ShiftMode {Logical, Arith, Rotate}, and the clog2 helper, SHALL live in the shared package used by LRShiftFlat.
REQ-033 The block SHALL use one sub-module, LRShiftStage (parameters width and amount = 2^k), which is combinational and implements the conditional shift or rotate for one stage.
REQ-034 LRShiftPipe SHALL instantiate LRShiftStage sw times and own all registers and handshake logic.

Verification (width = 8, sw = 3)
REQ-035 Accepting iBits=0x96, shift=3, Left, Logical with oReady=1 SHALL yield oBits=0xB0 with oValid=1 exactly 3 cycles later.
REQ-036 Back-to-back words 0x96 with shift=3 in Right/Arith, Right/Rotate and Left/Rotate modes SHALL yield 0xF2, 0xD2 and 0xB4 on consecutive cycles.
REQ-037 Driving oReady=0 for 4 cycles while the pipe is full SHALL hold iReady=0, keep oBits stable and lose no words; after release, all results SHALL appear in order.
REQ-038 An input of 0x5A with shift=0 in all modes and both directions SHALL return 0x5A; mode=3, Right, shift=1 on 0x80 SHALL return 0x40.
REQ-039 Asserting rst=0 with 3 words in flight SHALL drive oValid=0 and oBits=0 immediately, and no stale result SHALL appear after release.
REQ-040 A random iValid/oReady stress test against a reference model SHALL produce 0 mismatches and preserve order.
